// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage in-order pipeline: operand forwarding, load-use stall,
// branch flush and a multi-cycle load wait. Define HAZARD_PERF_CNT_EN to build the perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_x,
  input  logic [REG_AW-1:0] rs2_x,
  input  logic [REG_AW-1:0] rd_x,
  input  logic              mem_read_x,
  input  logic [REG_AW-1:0] rd_M,
  input  logic              reg_write_en_M,
  input  logic              mem_read_M,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              reg_write_en_wb,
  input  logic              branch_taken_x,
  input  logic              perf_clr,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_x,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_x,
  output logic [CNT_W-1:0]  load_use_cnt,
  output logic [CNT_W-1:0]  mem_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic       LAT_EN = (LOAD_LAT > 0);
  localparam logic [3:0] LAT_M1 = (LOAD_LAT > 0) ? 4'(LOAD_LAT - 1) : 4'd0;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       w_ms;
  logic       w_lu;
  logic       w_lu_eff;
  logic       w_br_eff;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] dst_m, input logic we_m,
                                         input logic [REG_AW-1:0] dst_wb, input logic we_wb);
    if (src == dst_m && we_m && src != '0)
      return 2'b10;
    else if (src == dst_wb && we_wb && src != '0)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign forwardA = fwd_sel(rs1_x, rd_M, reg_write_en_M, rd_wb, reg_write_en_wb);
  assign forwardB = fwd_sel(rs2_x, rd_M, reg_write_en_M, rd_wb, reg_write_en_wb);

  // The memory wait freezes X, so load-use and branch are deferred until it ends.
  assign w_ms     = (r_state == ST_IDLE) ? (mem_read_M && LAT_EN) : (r_cnt != 4'd0);
  assign w_lu     = mem_read_x && (rd_x != '0) && (rd_x == rs1_d || rd_x == rs2_d);
  assign w_br_eff = branch_taken_x && !w_ms;
  assign w_lu_eff = w_lu && !branch_taken_x && !w_ms;

  assign stall_f = rst_n && (w_ms || w_lu_eff);
  assign stall_d = rst_n && (w_ms || w_lu_eff);
  assign stall_x = rst_n && w_ms;
  assign stall_m = rst_n && w_ms;
  assign flush_d = rst_n && w_br_eff;
  assign flush_x = rst_n && (w_br_eff || w_lu_eff);

  // WAIT with cnt==0 releases the load and always returns to IDLE, so it cannot retrigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_read_M && LAT_EN) begin
            r_state <= ST_WAIT;
            r_cnt   <= LAT_M1;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0)
            r_state <= ST_IDLE;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_ms_cnt;
  logic [CNT_W-1:0] r_fl_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && !(&v))
      return v + CNT_W'(1);
    else
      return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_cnt <= '0;
      r_ms_cnt <= '0;
      r_fl_cnt <= '0;
    end else if (perf_clr) begin
      r_lu_cnt <= '0;
      r_ms_cnt <= '0;
      r_fl_cnt <= '0;
    end else begin
      r_lu_cnt <= sat_inc(r_lu_cnt, w_lu_eff);
      r_ms_cnt <= sat_inc(r_ms_cnt, w_ms);
      r_fl_cnt <= sat_inc(r_fl_cnt, w_br_eff);
    end
  end

  assign load_use_cnt  = r_lu_cnt;
  assign mem_stall_cnt = r_ms_cnt;
  assign flush_cnt     = r_fl_cnt;
`else
  logic w_unused_perf_clr;
  assign w_unused_perf_clr = perf_clr;
  assign load_use_cnt  = '0;
  assign mem_stall_cnt = '0;
  assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: three instances (LOAD_LAT 3, 2 and 0 with CNT_W=4)
// share one stimulus stream and are checked each cycle against a reference model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_M, rd_wb;
  logic       mem_read_x, reg_write_en_M, mem_read_M, reg_write_en_wb, branch_taken_x, perf_clr;

  logic [2:0][1:0]  fa, fb;
  logic [2:0]       sf, sd, sx, sm, fd, fx;
  logic [1:0][15:0] cl, cm, cf;
  logic [3:0]       cl4, cm4, cf4;

  pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_x(rs1_x), .rs2_x(rs2_x),
    .rd_x(rd_x), .mem_read_x(mem_read_x), .rd_M(rd_M), .reg_write_en_M(reg_write_en_M),
    .mem_read_M(mem_read_M), .rd_wb(rd_wb), .reg_write_en_wb(reg_write_en_wb),
    .branch_taken_x(branch_taken_x), .perf_clr(perf_clr), .forwardA(fa[0]), .forwardB(fb[0]),
    .stall_f(sf[0]), .stall_d(sd[0]), .stall_x(sx[0]), .stall_m(sm[0]), .flush_d(fd[0]),
    .flush_x(fx[0]), .load_use_cnt(cl[0]), .mem_stall_cnt(cm[0]), .flush_cnt(cf[0]));

  pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_x(rs1_x), .rs2_x(rs2_x),
    .rd_x(rd_x), .mem_read_x(mem_read_x), .rd_M(rd_M), .reg_write_en_M(reg_write_en_M),
    .mem_read_M(mem_read_M), .rd_wb(rd_wb), .reg_write_en_wb(reg_write_en_wb),
    .branch_taken_x(branch_taken_x), .perf_clr(perf_clr), .forwardA(fa[1]), .forwardB(fb[1]),
    .stall_f(sf[1]), .stall_d(sd[1]), .stall_x(sx[1]), .stall_m(sm[1]), .flush_d(fd[1]),
    .flush_x(fx[1]), .load_use_cnt(cl[1]), .mem_stall_cnt(cm[1]), .flush_cnt(cf[1]));

  pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(0), .CNT_W(4)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_x(rs1_x), .rs2_x(rs2_x),
    .rd_x(rd_x), .mem_read_x(mem_read_x), .rd_M(rd_M), .reg_write_en_M(reg_write_en_M),
    .mem_read_M(mem_read_M), .rd_wb(rd_wb), .reg_write_en_wb(reg_write_en_wb),
    .branch_taken_x(branch_taken_x), .perf_clr(perf_clr), .forwardA(fa[2]), .forwardB(fb[2]),
    .stall_f(sf[2]), .stall_d(sd[2]), .stall_x(sx[2]), .stall_m(sm[2]), .flush_d(fd[2]),
    .flush_x(fx[2]), .load_use_cnt(cl4), .mem_stall_cnt(cm4), .flush_cnt(cf4));

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int lat[3]  = '{3, 2, 0};
  int cmax[3] = '{65535, 65535, 15};
  int rem[3];
  bit cool[3];
  int mc_lu[3], mc_ms[3], mc_fl[3];
  bit e_ms[3], e_lu[3], e_br[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] s);
    if (s == rd_M && reg_write_en_M && s != 5'd0) return 2'b10;
    if (s == rd_wb && reg_write_en_wb && s != 5'd0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] actual(input int sel);
    int k;
    int j;
    k = sel / 4;
    j = sel % 4;
    case (j)
      0: return 32'({fa[k], fb[k], sf[k], sd[k], sx[k], sm[k], fd[k], fx[k]});
      1: return (k < 2) ? 32'(cl[k]) : 32'(cl4);
      2: return (k < 2) ? 32'(cm[k]) : 32'(cm4);
      default: return (k < 2) ? 32'(cf[k]) : 32'(cf4);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; cool[k] = 1'b0;
      mc_lu[k] = 0; mc_ms[k] = 0; mc_fl[k] = 0;
    end
  endtask

  task automatic push_expect();
    bit         lu;
    bit         g;
    logic [9:0] ctl;
    lu = mem_read_x && rd_x != 5'd0 && (rd_x == rs1_d || rd_x == rs2_d);
    g  = rst_n;
    for (int k = 0; k < 3; k++) begin
      e_ms[k] = (rem[k] > 0) ? 1'b1 : (cool[k] ? 1'b0 : (mem_read_M && lat[k] > 0));
      e_br[k] = branch_taken_x && !e_ms[k];
      e_lu[k] = lu && !branch_taken_x && !e_ms[k];
      ctl = {exp_fwd(rs1_x), exp_fwd(rs2_x),
             g && (e_ms[k] || e_lu[k]), g && (e_ms[k] || e_lu[k]),
             g && e_ms[k], g && e_ms[k],
             g && e_br[k], g && (e_br[k] || e_lu[k])};
      sb_q.push_back('{$sformatf("d%0d_ctl", k), k * 4, 32'(ctl)});
`ifdef HAZARD_PERF_CNT_EN
      sb_q.push_back('{$sformatf("d%0d_lu_cnt", k), k * 4 + 1, 32'(mc_lu[k])});
      sb_q.push_back('{$sformatf("d%0d_ms_cnt", k), k * 4 + 2, 32'(mc_ms[k])});
      sb_q.push_back('{$sformatf("d%0d_fl_cnt", k), k * 4 + 3, 32'(mc_fl[k])});
`else
      sb_q.push_back('{$sformatf("d%0d_lu_cnt", k), k * 4 + 1, 32'd0});
      sb_q.push_back('{$sformatf("d%0d_ms_cnt", k), k * 4 + 2, 32'd0});
      sb_q.push_back('{$sformatf("d%0d_fl_cnt", k), k * 4 + 3, 32'd0});
`endif
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, actual(e.sel), e.exp);
    end
  endtask

  task automatic model_seq();
    for (int k = 0; k < 3; k++) begin
      if (rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 0) cool[k] = 1'b1;
      end else if (cool[k]) begin
        cool[k] = 1'b0;
      end else if (mem_read_M && lat[k] > 0) begin
        rem[k] = lat[k] - 1;
        if (rem[k] == 0) cool[k] = 1'b1;
      end
      if (perf_clr) begin
        mc_lu[k] = 0; mc_ms[k] = 0; mc_fl[k] = 0;
      end else begin
        if (e_lu[k] && mc_lu[k] < cmax[k]) mc_lu[k]++;
        if (e_ms[k] && mc_ms[k] < cmax[k]) mc_ms[k]++;
        if (e_br[k] && mc_fl[k] < cmax[k]) mc_fl[k]++;
      end
    end
  endtask

  // Inputs are set before the call; outputs are sampled on the falling edge.
  task automatic step(input bit release_mid = 1'b0);
    if (!rst_n) model_reset();
    push_expect();
    @(negedge clk);
    drain();
    if (release_mid) rst_n = 1'b1;
    @(posedge clk);
    if (rst_n) model_seq();
    #1;
  endtask

  task automatic idle();
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_x = 5'd0; rs2_x = 5'd0; rd_x = 5'd0; rd_M = 5'd0; rd_wb = 5'd0;
    mem_read_x = 1'b0; reg_write_en_M = 1'b0; mem_read_M = 1'b0; reg_write_en_wb = 1'b0;
    branch_taken_x = 1'b0; perf_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #1;
    // Reset held: forwarding live, all stalls/flushes forced low.
    rs1_x = 5'd5; rd_M = 5'd5; reg_write_en_M = 1'b1;
    mem_read_M = 1'b1; mem_read_x = 1'b1; rd_x = 5'd3; rs2_d = 5'd3; branch_taken_x = 1'b1;
    step(); step();
    idle(); rst_n = 1'b1;
    step();

    // Forwarding priority and register-zero handling.
    rs1_x = 5'd5; rd_M = 5'd5; reg_write_en_M = 1'b1; rd_wb = 5'd5; reg_write_en_wb = 1'b1;
    rs2_x = 5'd5;
    step();
    rd_M = 5'd6;
    step();
    reg_write_en_wb = 1'b0; rs2_x = 5'd6;
    step();
    rs1_x = 5'd0; rs2_x = 5'd0; rd_M = 5'd0; rd_wb = 5'd0; reg_write_en_wb = 1'b1;
    step();
    rs1_x = 5'd16; rd_M = 5'd16; reg_write_en_M = 1'b0; rd_wb = 5'd16;
    step();
    idle();

    // Load-use, then branch overriding it.
    mem_read_x = 1'b1; rd_x = 5'd3; rs2_d = 5'd3;
    step();
    branch_taken_x = 1'b1;
    step();
    branch_taken_x = 1'b0; rd_x = 5'd0; rs2_d = 5'd0;
    step();
    idle();

    // Memory wait held high, with load-use and branch arriving during the stall.
    mem_read_M = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_read_x     = (i == 1 || i == 3);
      rd_x           = 5'd7;
      rs1_d          = 5'd7;
      branch_taken_x = (i == 2 || i == 5);
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) step();

    // Reset during the first wait cycle, released before the next edge.
    mem_read_M = 1'b1;
    step();
    mem_read_M = 1'b0; rst_n = 1'b0;
    step(1'b1);
    mem_read_M = 1'b1;
    step();
    mem_read_M = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Counter saturation on the CNT_W=4 instance, then clear.
    mem_read_x = 1'b1; rd_x = 5'd9; rs1_d = 5'd9;
    for (int i = 0; i < 20; i++) step();
    branch_taken_x = 1'b1;
    for (int i = 0; i < 3; i++) step();
    idle(); perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    step();

    // Randomised traffic over a small register window.
    for (int i = 0; i < 150; i++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_x = 5'($urandom_range(0, 3)); rs2_x = 5'($urandom_range(0, 3));
      rd_x  = 5'($urandom_range(0, 3)); rd_M  = 5'($urandom_range(0, 3));
      rd_wb = 5'($urandom_range(0, 3));
      mem_read_x      = ($urandom_range(0, 2) == 0);
      reg_write_en_M  = $urandom_range(0, 1) != 0;
      reg_write_en_wb = $urandom_range(0, 1) != 0;
      mem_read_M      = ($urandom_range(0, 5) == 0);
      branch_taken_x  = ($urandom_range(0, 7) == 0);
      perf_clr        = ($urandom_range(0, 19) == 0);
      step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
